// File: rtl/uart_frame_parser.sv
// uart_frame_parser: byte-level SYNC/LEN/payload/XOR-CHK frame decoder with buffered valid/ready drain
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_data, rx_valid     : byte strobes from the UART receiver
//   out_data/valid/last   : validated payload stream, out_ready is the consumer handshake
//   frame_ok, frame_err   : one-cycle verdict pulses, err_code holds the last error (1 len, 2 chk, 3 timeout)
//   overrun               : one-cycle pulse when a byte arrives while the buffer is still draining
//   busy                  : high whenever the parser is not hunting for a sync byte
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 208320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          wr_en, last_idx;
    // Sized to the full index range so the index widths match the array exactly
    logic [7:0]    mem_q [2**IW];

    assign last_idx  = rd_idx_q == len_q - IW'(1);
    assign out_data  = out_valid_q ? mem_q[rd_idx_q] : 8'd0;
    assign out_last  = out_valid_q && last_idx;
    assign out_valid = out_valid_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        chk_d       = chk_q;
        tmo_d       = '0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;
        // Idle-gap counter: any strobe (or leaving HUNT) restarts it
        if (state_q inside {LEN, PAYLOAD, CHECK} && !rx_valid)
            tmo_d = tmo_q + 32'd1;
        case (state_q)
            HUNT: if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN;
            LEN: if (rx_valid) begin
                if (rx_data == 8'd0 || rx_data > MAX8) begin
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd1;
                    state_d     = HUNT;
                end else begin
                    len_d    = rx_data[IW-1:0];
                    chk_d    = rx_data;
                    wr_idx_d = '0;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: if (rx_valid) begin
                wr_en    = 1'b1;
                chk_d    = chk_q ^ rx_data;
                wr_idx_d = wr_idx_q + IW'(1);
                if (wr_idx_d == len_q) state_d = CHECK;
            end
            CHECK: if (rx_valid) begin
                if (rx_data == chk_q) begin
                    frame_ok_d = 1'b1;
                    rd_idx_d   = '0;
                    state_d    = DRAIN;
                end else begin
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd2;
                    state_d     = HUNT;
                end
            end
            DRAIN: begin
                // Any byte arriving here is lost, including a SYNC on the final handshake
                overrun_d = rx_valid;
                if (out_valid_q && out_ready) begin
                    if (last_idx) state_d = HUNT;
                    else rd_idx_d = rd_idx_q + IW'(1);
                end
            end
            default: state_d = HUNT;
        endcase
        if (tmo_d == 32'(TIMEOUT_CYCLES)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = HUNT;
        end
        out_valid_d = state_d == DRAIN;
        busy_d      = state_d != HUNT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload storage is never cleared; only the indices are reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx_q] <= rx_data;
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench with directed frames plus randomized frame traffic
module tb_uart_frame_parser;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 100;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_ok, frame_err, overrun, busy;
    logic [1:0] err_code;

    uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; logic [1:0] code;} ev_t;
    ev_t        ev_q[$];
    logic [8:0] dat_q[$];
    logic [7:0] tx_q[$];
    int         n_tests = 0, n_fail = 0;
    bit         ready_rnd = 1'b0;
    logic       ready_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_ev(input int kind, input logic [1:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        ev_q.push_back(e);
    endtask

    // Expected good frame: ok event, then the payload bytes with last on the final one
    task automatic exp_good(input logic [7:0] pl[$]);
        exp_ev(0, 2'd0);
        foreach (pl[i]) dat_q.push_back({i == pl.size() - 1, pl[i]});
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] len, input logic [7:0] pl[$]);
        logic [7:0] c = len;
        foreach (pl[i]) c ^= pl[i];
        return c;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_all(input int gapmax);
        foreach (tx_q[i]) begin
            send(tx_q[i]);
            idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while ((busy || ev_q.size() != 0 || dat_q.size() != 0) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({name, " completion"}, 32'(c < 3000), 1);
    endtask

    // Builds one random frame of a given kind and queues the expected response
    task automatic gen_frame(input int kind);
        logic [7:0] pl[$];
        logic [7:0] b, len;
        tx_q.delete();
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            tx_q.push_back(b == 8'hA5 ? 8'h00 : b);
        end
        if (kind <= 1) begin
            len = 8'($urandom_range(1, MAX_LEN));
            repeat (int'(len)) pl.push_back(8'($urandom));
            tx_q.push_back(8'hA5);
            tx_q.push_back(len);
            foreach (pl[i]) tx_q.push_back(pl[i]);
            if (kind == 0) begin
                tx_q.push_back(xsum(len, pl));
                exp_good(pl);
            end else begin
                tx_q.push_back(xsum(len, pl) ^ 8'($urandom_range(1, 255)));
                exp_ev(1, 2'd2);
            end
        end else if (kind == 2) begin
            tx_q.push_back(8'hA5);
            tx_q.push_back($urandom_range(0, 1) != 0 ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
            exp_ev(1, 2'd1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = ready_rnd ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    initial begin
        ev_t        e;
        logic [8:0] d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_ok) begin
                    if (ev_q.size() == 0) check("unexpected frame_ok", 1, 0);
                    else begin
                        e = ev_q.pop_front();
                        check("event frame_ok", 0, e.kind);
                        check("frame_ok with out_valid", out_valid, 1);
                    end
                end
                if (frame_err) begin
                    if (ev_q.size() == 0) check("unexpected frame_err", 1, 0);
                    else begin
                        e = ev_q.pop_front();
                        check("event frame_err", 1, e.kind);
                        check("err_code", err_code, e.code);
                    end
                end
                if (overrun) begin
                    if (ev_q.size() == 0) check("unexpected overrun", 1, 0);
                    else begin
                        e = ev_q.pop_front();
                        check("event overrun", 2, e.kind);
                    end
                end
                if (out_valid && out_ready) begin
                    if (dat_q.size() == 0) check("unexpected out byte", {out_last, out_data}, 0);
                    else begin
                        d = dat_q.pop_front();
                        check("out {last,data}", {out_last, out_data}, d);
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        idle(3);
        check("reset outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, overrun, busy}, 0);
        rst_n = 1'b1;
        ready_force = 1'b1;
        idle(2);

        exp_good('{8'h11, 8'h22, 8'h33});
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_all(0);
        wait_done("good frame");
        check("busy after drain", busy, 0);

        exp_ev(1, 2'd2);
        tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF};
        send_all(0);
        wait_done("bad checksum");
        exp_good('{8'h7E});
        tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_all(0);
        wait_done("frame after bad checksum");

        tx_q = '{8'h00, 8'hFF, 8'h5A};
        send_all(0);
        idle(2);
        check("busy after junk", busy, 0);
        exp_ev(1, 2'd1);
        exp_ev(1, 2'd1);
        tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h11};
        send_all(0);
        wait_done("bad length");
        check("err_code held", err_code, 1);

        exp_ev(1, 2'd3);
        tx_q = '{8'hA5, 8'h02, 8'h10};
        send_all(0);
        for (lat = 0; lat < 200; lat++) begin
            @(negedge clk);
            if (frame_err) break;
        end
        check("timeout latency", 32'(lat), 100);
        check("busy after timeout", busy, 0);
        @(posedge clk);
        #1;
        wait_done("timeout");

        ready_force = 1'b0;
        idle(1);
        exp_good('{8'h3C, 8'h4D, 8'h5E});
        tx_q = '{8'hA5, 8'h03, 8'h3C, 8'h4D, 8'h5E, xsum(8'h03, '{8'h3C, 8'h4D, 8'h5E})};
        send_all(0);
        repeat (5) begin
            @(negedge clk);
            check("held under backpressure", {out_valid, out_last, out_data}, {2'b10, 8'h3C});
        end
        @(posedge clk);
        #1;
        exp_ev(2, 2'd0);
        send(8'hA5);
        ready_force = 1'b1;
        wait_done("overrun drain");
        tx_q = '{8'h01, 8'h7E, 8'h7F};
        send_all(0);
        idle(3);
        check("no frame from dropped sync", busy, 0);

        tx_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_all(0);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, overrun, busy}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        exp_good('{8'h7E});
        tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_all(0);
        wait_done("frame after reset");

        ready_rnd = 1'b1;
        repeat (60) begin
            gen_frame($urandom_range(0, 3));
            send_all(2);
            wait_done("random frame");
        end

        check("scoreboard empty", 32'(ev_q.size() + dat_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame decoder downstream of the UART receiver. Consumes one-cycle `rx_valid` byte strobes and hunts for a sync byte. Collects a length-prefixed payload into an internal buffer and verifies an XOR checksum. Releases validated payloads on a valid/ready byte stream with a last marker for the command logic; malformed, truncated or stalled frames are discarded and reported via error pulses.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_LEN`, 16, maximum payload bytes (1..255)
- `TIMEOUT_CYCLES`, 208320, idle clk cycles between bytes inside a frame before abort (≈4 byte times at 9600 baud/50 MHz)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_data`  in  8  received byte, sampled only when `rx_valid`=1
- `rx_valid`  in  1  one-cycle strobe per received byte
- `out_data`  out  8  payload byte, meaningful while `out_valid`=1
- `out_valid`  out  1  payload byte available
- `out_ready`  in  1  consumer accepts byte when `out_valid`&&`out_ready`
- `out_last`  out  1  marks final payload byte of frame
- `frame_ok`  out  1  one-cycle pulse: frame accepted
- `frame_err`  out  1  one-cycle pulse: frame rejected
- `err_code`  out  2  last error: 1 bad length, 2 checksum, 3 timeout; held until next error
- `overrun`  out  1  one-cycle pulse: byte dropped while draining
- `busy`  out  1  high in any state except HUNT

## Operation
- Frame format: SYNC, LEN (1..MAX_LEN), LEN payload bytes, CHK, where CHK = LEN ^ payload[0] ^ … ^ payload[LEN-1].
- States: HUNT, LEN, PAYLOAD, CHECK, DRAIN.
- HUNT: bytes ≠ SYNC_BYTE ignored silently; SYNC_BYTE → LEN.
- LEN: byte 0 or > MAX_LEN → frame_err, err_code=1, HUNT. Otherwise store len, init running checksum = byte, wr_idx=0 → PAYLOAD.
- PAYLOAD: each byte written to buf[wr_idx], XOR into checksum, wr_idx++; after byte number len → CHECK.
- CHECK: byte == checksum → frame_ok, rd_idx=0, DRAIN; else frame_err, err_code=2, HUNT.
- DRAIN: out_data=buf[rd_idx], out_valid=1, out_last=(rd_idx==len-1). Handshake advances rd_idx; handshake on the last byte → HUNT. A SYNC in the same cycle as that last handshake is dropped (overrun).
- rx_valid in DRAIN: byte dropped, overrun pulse; no state change.
- Timeout: cycle counter cleared on every rx_valid and on entry to LEN; counts only in LEN/PAYLOAD/CHECK. Reaching TIMEOUT_CYCLES → frame_err, err_code=3, HUNT. No timeout in HUNT or DRAIN (consumer may stall indefinitely).
- Checksum 8-bit XOR; counters sized $clog2(MAX_LEN+1); timeout counter 32 bits.
- Buffer contents are not cleared between frames; only indices reset.

## Timing
- Reset values: out_data 0, out_valid 0, out_last 0, frame_ok 0, frame_err 0, err_code 0, overrun 0, busy 0; state HUNT.
- Reset asserted mid-frame or mid-drain: immediate abort, no pulses, all outputs to reset values.
- All outputs registered except out_data/out_last, which decode registered rd_idx/len from buffer.
- State updates in the cycle after the rx_valid cycle.
- frame_ok pulses in the first DRAIN cycle, the same cycle out_valid first rises (1 cycle after the CHK strobe).
- frame_err pulses 1 cycle after the offending strobe, or in the cycle the counter reaches TIMEOUT_CYCLES.
- Drain throughput one byte/cycle with out_ready held high; out_data/out_last stable while out_valid && !out_ready.
- Accepts back-to-back rx_valid strobes every cycle.

## Test plan
- Good frame: A5 03 11 22 33 03 → frame_ok once; stream 11,22,33 with out_last only on 33; busy drops after last handshake.
- Bad checksum: A5 02 10 20 FF → frame_err, err_code=2, no out_valid; next A5 01 7E 7F accepted → output 7E (last).
- Bad length: A5 00 → err_code=1; A5 11 (17 > MAX_LEN) → err_code=1; leading bytes 00 FF 5A before A5 ignored with no pulses.
- Timeout (TIMEOUT_CYCLES=100): A5 02 10 then idle → frame_err, err_code=3 exactly 100 cycles after the 10 strobe; busy low.
- Backpressure/overrun: valid 3-byte frame, out_ready low 5 cycles → out_data held at first byte; A5 sent during DRAIN → overrun pulse, no new frame started.
- Reset mid-PAYLOAD after A5 04 01 02: all outputs return to reset values; following good frame decodes correctly.
